snapshot_upload: RTL and testbench

Streams a machine snapshot out to the HPS over the ioctl upload channel: a 256-byte header served from a small register-capture store, followed by the CPC RAM image read byte by byte from SDRAM. This is the read-back counterpart of the boot/expansion ROM loader. It sits in `emu` beside that loader. While `busy` is high it owns the SDRAM `oe`/`addr`/`bank` mux, in the same way the loader owns `we` during download.

---
 rtl/snapshot_upload.sv | 141 ++++++++++++++
 tb/tb_snapshot_upload.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/snapshot_upload.sv
// Snapshot upload: serves a 256-byte header from the register-capture store,
// then the CPC RAM image read byte by byte from SDRAM over the ioctl upload channel.
module snapshot_upload #(
  parameter int RAM_PAGES = 8,
  parameter int HDR_BYTES = 256
) (
  input  logic        clk_sys_i,
  input  logic        reset_i,
  input  logic        ce_ref_i,
  input  logic        ioctl_upload_i,
  input  logic        ioctl_rd_i,
  input  logic [24:0] ioctl_addr_i,
  output logic [7:0]  ioctl_din_o,
  output logic        ioctl_wait_o,
  output logic [7:0]  hdr_a_o,
  input  logic [7:0]  hdr_d_i,
  output logic        mem_rd_o,
  output logic [22:0] mem_addr_o,
  input  logic [7:0]  mem_dout_i,
  output logic        busy_o
);

  localparam logic [25:0] RAM_BYTES = 26'(RAM_PAGES) << 14;
  localparam logic [24:0] HDR_LEN   = 25'(HDR_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_RANGE,
    S_MEM_REQ,
    S_MEM_DATA
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic        mem_rd_q, mem_rd_d;
  logic [22:0] mem_addr_q, mem_addr_d;
  logic [7:0]  hdr_a_q, hdr_a_d;
  logic        busy_q;

  logic [24:0] off;
  logic        is_hdr;
  logic        in_ram;

  // RAM image starts right after the header in the file.
  assign off    = ioctl_addr_i - HDR_LEN;
  assign is_hdr = ioctl_addr_i < HDR_LEN;
  assign in_ram = {1'b0, off} < RAM_BYTES;

  always_comb begin
    state_d    = state_q;
    din_d      = din_q;
    wait_d     = wait_q;
    mem_rd_d   = mem_rd_q;
    mem_addr_d = mem_addr_q;
    hdr_a_d    = hdr_a_q;

    if (!ioctl_upload_i) begin
      // Abort: release the HPS and SDRAM, keep the last byte on din.
      state_d  = S_IDLE;
      wait_d   = 1'b0;
      mem_rd_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ioctl_rd_i) begin
            wait_d = 1'b1;
            if (is_hdr) begin
              hdr_a_d = ioctl_addr_i[7:0];
              state_d = S_HDR;
            end else if (!in_ram) begin
              state_d = S_RANGE;
            end else begin
              // Bit 22 forced low keeps ROM pages out of the export.
              mem_addr_d = {1'b0, off[21:0]};
              state_d    = S_MEM_REQ;
            end
          end
        end
        S_HDR: begin
          din_d   = hdr_d_i;
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end
        S_RANGE: begin
          din_d   = 8'hFF;
          wait_d  = 1'b0;
          state_d = S_IDLE;
        end
        S_MEM_REQ: begin
          if (ce_ref_i) begin
            mem_rd_d = 1'b1;
            state_d  = S_MEM_DATA;
          end
        end
        S_MEM_DATA: begin
          if (ce_ref_i) begin
            din_d    = mem_dout_i;
            mem_rd_d = 1'b0;
            wait_d   = 1'b0;
            state_d  = S_IDLE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          wait_d   = 1'b0;
          mem_rd_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      din_q      <= 8'hFF;
      wait_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      hdr_a_q    <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      din_q      <= din_d;
      wait_q     <= wait_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      hdr_a_q    <= hdr_a_d;
      busy_q     <= ioctl_upload_i;
    end
  end

  assign ioctl_din_o  = din_q;
  assign ioctl_wait_o = wait_q;
  assign mem_rd_o     = mem_rd_q;
  assign mem_addr_o   = mem_addr_q;
  assign hdr_a_o      = hdr_a_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_snapshot_upload.sv
// Bench for snapshot_upload: transaction-level schedule model checked every cycle,
// directed literal reads, randomized reads/aborts and sequential stream windows.
module tb_snapshot_upload;

  localparam int RAM_PAGES = 8;
  localparam int RAM_LIM   = RAM_PAGES * 16384;

  logic        clk = 1'b0;
  logic        reset;
  logic        ce_ref;
  logic        upload;
  logic        rd;
  logic [24:0] addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [7:0]  hdr_a;
  logic [7:0]  hdr_d;
  logic        mem_rd;
  logic [22:0] mem_addr;
  logic [7:0]  mem_dout;
  logic        busy;

  always #5 clk = ~clk;

  // Header store holds i^5A at i; SDRAM returns the low address byte.
  assign hdr_d    = hdr_a ^ 8'h5A;
  assign mem_dout = mem_addr[7:0];

  snapshot_upload #(.RAM_PAGES(RAM_PAGES)) dut (
    .clk_sys_i      (clk),
    .reset_i        (reset),
    .ce_ref_i       (ce_ref),
    .ioctl_upload_i (upload),
    .ioctl_rd_i     (rd),
    .ioctl_addr_i   (addr),
    .ioctl_din_o    (ioctl_din),
    .ioctl_wait_o   (ioctl_wait),
    .hdr_a_o        (hdr_a),
    .hdr_d_i        (hdr_d),
    .mem_rd_o       (mem_rd),
    .mem_addr_o     (mem_addr),
    .mem_dout_i     (mem_dout),
    .busy_o         (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int ce_ph = 0;

  // Expected outputs after the most recent edge.
  bit          m_valid = 0;
  logic [7:0]  m_din, m_hdra, m_byte;
  logic        m_wait, m_rd, m_busy;
  logic [22:0] m_maddr;
  bit          m_pend, m_isram;
  int          m_c1, m_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit ce_at(input int e);
    return (e % 16) == ce_ph;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [24:0] a);
    logic [24:0] o;
    if (a < 25'd256) return a[7:0] ^ 8'h5A;
    o = a - 25'd256;
    return (o < 25'(RAM_LIM)) ? o[7:0] : 8'hFF;
  endfunction

  // Model: each request gets a completion edge computed from the ce schedule.
  task automatic model_edge();
    int n;
    logic [24:0] o;
    n = cyc;
    m_valid = 1;
    if (reset) begin
      m_din = 8'hFF; m_wait = 0; m_rd = 0; m_maddr = '0; m_hdra = '0;
      m_busy = 0; m_pend = 0;
      return;
    end
    m_busy = upload;
    if (!upload) begin
      m_pend = 0; m_wait = 0; m_rd = 0;
      return;
    end
    if (m_pend) begin
      m_rd = m_isram && n >= m_c1 && n < m_done;
      if (n == m_done) begin
        m_din = m_byte; m_wait = 0; m_pend = 0; m_rd = 0;
      end
    end else if (rd) begin
      m_pend = 1; m_wait = 1; m_isram = 0; m_rd = 0;
      if (addr < 25'd256) begin
        m_hdra = addr[7:0]; m_byte = addr[7:0] ^ 8'h5A; m_done = n + 1;
      end else begin
        o = addr - 25'd256;
        if (o >= 25'(RAM_LIM)) begin
          m_byte = 8'hFF; m_done = n + 1;
        end else begin
          m_isram = 1;
          m_maddr = {1'b0, o[21:0]};
          m_byte  = o[7:0];
          m_c1 = n + 1;
          while (!ce_at(m_c1)) m_c1++;
          m_done = m_c1 + 16;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("din",      ioctl_din,  m_din);
      chk("wait",     ioctl_wait, m_wait);
      chk("busy",     busy,       m_busy);
      chk("mem_rd",   mem_rd,     m_rd);
      chk("mem_addr", mem_addr,   m_maddr);
      chk("hdr_a",    hdr_a,      m_hdra);
    end
  end

  task automatic step();
    ce_ref = ce_at(cyc + 1);
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
  endtask

  task automatic rd_byte(input logic [24:0] a, output logic [7:0] d,
                         output int lat, output int rdcnt);
    rd = 1; addr = a;
    step();
    rd = 0; lat = 1; rdcnt = 0;
    while (ioctl_wait && lat < 64) begin
      step();
      lat++;
      if (mem_rd) rdcnt++;
    end
    if (lat >= 64) chk("read_timeout", 32'(lat), 32'd0);
    d = ioctl_din;
  endtask

  task automatic rd_lit(input string nm, input logic [24:0] a, input logic [7:0] exp_d);
    logic [7:0] d; int lat, rc;
    rd_byte(a, d, lat, rc);
    chk(nm, d, exp_d);
    if (a < 25'h100 || a >= 25'(RAM_LIM + 256)) begin
      chk({nm, "_lat"}, 32'(lat), 32'd2);
      chk({nm, "_nord"}, 32'(rc), 32'd0);
    end else begin
      chk({nm, "_lat_rng"}, 32'(lat >= 18 && lat <= 34), 32'd1);
      chk({nm, "_rd16"}, 32'(rc), 32'd16);
    end
  endtask

  task automatic rd_stream(input logic [24:0] lo, input logic [24:0] hi);
    logic [7:0] d; int lat, rc;
    for (int a = int'(lo); a <= int'(hi); a++) begin
      rd_byte(25'(a), d, lat, rc);
      chk("stream", d, exp_byte(25'(a)));
      if (a < 256) chk("stream_nord", 32'(rc), 32'd0);
      step();
    end
  endtask

  initial begin
    logic [7:0] d;
    int lat, rc, k;
    logic [24:0] a;
    ce_ph = int'($urandom_range(0, 15));
    reset = 1; upload = 0; rd = 0; addr = '0; ce_ref = 0;
    step(); step();
    chk("rst_din", ioctl_din, 8'hFF);
    chk("rst_wait", ioctl_wait, 1'b0);
    chk("rst_memrd", mem_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset = 0; upload = 1;
    step();
    chk("busy_up", busy, 1'b1);

    rd_lit("hdr_000", 25'h000, 8'h5A);
    rd_lit("hdr_07f", 25'h07F, 8'h25);
    rd_lit("hdr_0ff", 25'h0FF, 8'hA5);
    rd_lit("ram_100", 25'h100, 8'h00);
    chk("ram_100_addr", mem_addr, 23'h0);
    rd_lit("ram_4133", 25'h4133, 8'h33);
    chk("ram_4133_addr", mem_addr, 23'h4033);
    rd_lit("ram_last", 25'h200FF, 8'hFF);
    chk("ram_last_addr", mem_addr, 23'h1FFFF);
    rd_lit("range_20100", 25'h20100, 8'hFF);
    rd_lit("range_big", 25'h1FFFFFF, 8'hFF);

    // Abort while waiting for data.
    rd = 1; addr = 25'h4133; step(); rd = 0;
    k = 0;
    while (!mem_rd && k < 40) begin step(); k++; end
    chk("abort_reach_data", 32'(mem_rd), 32'd1);
    step();
    upload = 0; step();
    chk("abort_wait", ioctl_wait, 1'b0);
    chk("abort_memrd", mem_rd, 1'b0);
    chk("abort_busy", busy, 1'b0);
    // A read strobe while upload is low is ignored.
    rd = 1; addr = 25'h0; step(); rd = 0;
    chk("rd_no_upload", ioctl_wait, 1'b0);
    upload = 1; step();
    rd_lit("after_abort", 25'h010, 8'h4A);

    // Reset while waiting for the SDRAM slot.
    rd = 1; addr = 25'h100; step(); rd = 0;
    reset = 1; step(); reset = 0;
    chk("midrst_din", ioctl_din, 8'hFF);
    chk("midrst_wait", ioctl_wait, 1'b0);
    chk("midrst_addr", mem_addr, 23'h0);
    chk("midrst_busy", busy, 1'b0);
    rd_lit("after_rst", 25'h000, 8'h5A);

    // Randomized reads across all regions, with occasional aborts.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0: a = 25'($urandom_range(0, 255));
        1: a = 25'($urandom_range(256, RAM_LIM + 255));
        2: a = 25'($urandom_range(RAM_LIM + 240, RAM_LIM + 272));
        default: a = 25'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) begin
        rd = 1; addr = a; step(); rd = 0;
        k = int'($urandom_range(0, 20));
        for (int j = 0; j < k; j++) step();
        upload = 0; step(); upload = 1; step();
      end else begin
        rd_byte(a, d, lat, rc);
        chk("rand", d, exp_byte(a));
      end
      k = int'($urandom_range(0, 3));
      for (int j = 0; j < k; j++) step();
    end

    // Sequential stream windows: full header, RAM start, page edge, RAM end.
    rd_stream(25'h000, 25'h0FF);
    rd_stream(25'h100, 25'h13F);
    rd_stream(25'h40F0, 25'h410F);
    rd_stream(25'h200E0, 25'h20108);

    upload = 0; step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
